// File: rtl/map_access_sched.sv
// rtl/map_access_sched.sv - scroll sequencer and shared map ROM access arbiter
module map_access_sched #(
    parameter int MAP_LEN    = 87,
    parameter int LANES      = 5,
    parameter int VIEW_ROWS  = 15,
    parameter int Y_W        = 7,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           pause,
    input  logic           scroll_tick,
    input  logic           col_req,
    input  logic [2:0]     col_lane,
    input  logic [Y_W-1:0] col_row,
    output logic           col_gnt,
    output logic           col_valid,
    output logic [2:0]     col_state,
    input  logic           rd_req,
    input  logic [2:0]     rd_lane,
    input  logic [Y_W-1:0] rd_row,
    output logic           rd_gnt,
    output logic           rd_valid,
    output logic [2:0]     rd_state,
    output logic [2:0]     map_index_x,
    output logic [Y_W-1:0] map_index_y,
    input  logic [2:0]     map_state,
    output logic [Y_W-1:0] scroll_pos,
    output logic [1:0]     run_state,
    output logic           level_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } run_t;

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [Y_W-1:0]  SCROLL_END = Y_W'(MAP_LEN - VIEW_ROWS);
    localparam logic [Y_W:0]    MAP_LEN_W  = (Y_W+1)'(MAP_LEN);
    localparam logic [2:0]      LANES_W    = 3'(LANES);
    localparam logic [SC_W-1:0] STARVE_W   = SC_W'(STARVE_MAX);

    run_t           state;
    logic [Y_W-1:0] scroll_q;
    logic [Y_W-1:0] scroll_inc;

    assign scroll_inc = scroll_q + Y_W'(1);
    assign scroll_pos = scroll_q;
    assign run_state  = state;

    // start wins over pause, and pause wins over a same-cycle tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            scroll_q   <= '0;
            level_done <= 1'b0;
        end else if (start) begin
            state      <= S_RUN;
            scroll_q   <= '0;
            level_done <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (pause) begin
                        state <= S_PAUSED;
                    end else if (scroll_tick) begin
                        scroll_q <= scroll_inc;
                        if (scroll_inc == SCROLL_END) begin
                            state      <= S_DONE;
                            level_done <= 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    logic [SC_W-1:0] starve_cnt;
    logic            rd_force;

    // renderer is forced through once it has watched STARVE_MAX collision grants
    assign rd_force = rd_req && (starve_cnt >= STARVE_W);
    assign col_gnt  = rst_n && col_req && !rd_force;
    assign rd_gnt   = rst_n && rd_req && !col_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!rd_req || rd_gnt) begin
            starve_cnt <= '0;
        end else if (col_gnt && (starve_cnt != STARVE_W)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    logic           any_gnt;
    logic [2:0]     sel_lane;
    logic [Y_W-1:0] sel_row;
    logic [Y_W:0]   abs_row;
    logic           lane_oor;
    logic           row_oor;

    assign any_gnt  = col_gnt || rd_gnt;
    assign sel_lane = col_gnt ? col_lane : rd_lane;
    assign sel_row  = col_gnt ? col_row : rd_row;
    assign abs_row  = {1'b0, scroll_q} + {1'b0, sel_row};
    assign lane_oor = (sel_lane >= LANES_W);
    assign row_oor  = (abs_row >= MAP_LEN_W);

    logic       s1_valid, s1_rd, s1_oor;
    logic [2:0] s1_fix;
    logic       s2_valid, s2_rd, s2_oor;
    logic [2:0] s2_fix;

    // two-stage tag tracks owner and out-of-range substitute alongside the ROM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_rd       <= 1'b0;
            s1_oor      <= 1'b0;
            s1_fix      <= '0;
            s2_valid    <= 1'b0;
            s2_rd       <= 1'b0;
            s2_oor      <= 1'b0;
            s2_fix      <= '0;
            map_index_x <= '0;
            map_index_y <= '0;
        end else begin
            s1_valid <= any_gnt;
            s1_rd    <= rd_gnt;
            s1_oor   <= lane_oor || row_oor;
            s1_fix   <= lane_oor ? 3'd1 : 3'd0;
            if (any_gnt && !lane_oor && !row_oor) begin
                map_index_x <= sel_lane;
                map_index_y <= abs_row[Y_W-1:0];
            end
            s2_valid <= s1_valid;
            s2_rd    <= s1_rd;
            s2_oor   <= s1_oor;
            s2_fix   <= s1_fix;
        end
    end

    logic [2:0] res_state;

    assign res_state = s2_oor ? s2_fix : map_state;
    assign col_valid = s2_valid && !s2_rd;
    assign rd_valid  = s2_valid && s2_rd;
    assign col_state = col_valid ? res_state : 3'd0;
    assign rd_state  = rd_valid ? res_state : 3'd0;

endmodule

// File: tb/tb_map_access_sched.sv
// tb/tb_map_access_sched.sv - scoreboard bench for map_access_sched
module tb_map_access_sched;
    localparam int Y_W = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0, pause = 1'b0, scroll_tick = 1'b0;
    logic           col_req = 1'b0, rd_req = 1'b0;
    logic [2:0]     col_lane = '0, rd_lane = '0;
    logic [Y_W-1:0] col_row = '0, rd_row = '0;
    logic           col_gnt, col_valid, rd_gnt, rd_valid, level_done;
    logic [2:0]     col_state, rd_state, map_index_x;
    logic [Y_W-1:0] map_index_y, scroll_pos;
    logic [1:0]     run_state;
    logic [2:0]     map_state = '0;

    always #5 clk = ~clk;

    map_access_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .scroll_tick(scroll_tick),
        .col_req(col_req), .col_lane(col_lane), .col_row(col_row),
        .col_gnt(col_gnt), .col_valid(col_valid), .col_state(col_state),
        .rd_req(rd_req), .rd_lane(rd_lane), .rd_row(rd_row),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_state(rd_state),
        .map_index_x(map_index_x), .map_index_y(map_index_y), .map_state(map_state),
        .scroll_pos(scroll_pos), .run_state(run_state), .level_done(level_done)
    );

    function automatic logic [2:0] rom_f(input logic [2:0] x, input logic [Y_W-1:0] y);
        return 3'((int'(x) * 5 + int'(y) * 7) % 3);
    endfunction

    always @(posedge clk) map_state <= rom_f(map_index_x, map_index_y);

    typedef struct {
        int         due;
        bit         owner;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0, tests_failed = 0, cyc = 0;
    int   m_state = 0, m_scroll = 0, m_cnt = 0, m_ix = 0, m_iy = 0;

    function automatic logic [1:0] arb_exp();
        logic frc, eg, er;
        frc = rd_req && (m_cnt >= 3);
        eg  = col_req && !frc;
        er  = rd_req && !eg;
        return {er, eg};
    endfunction

    task automatic next_clk();
        logic [1:0] g;
        g = arb_exp();
        @(posedge clk);
        if (!rd_req || g[1]) m_cnt = 0;
        else if (g[0] && m_cnt < 3) m_cnt++;
        if (start) begin
            m_state = 1; m_scroll = 0;
        end else if (m_state == 1) begin
            if (pause) m_state = 2;
            else if (scroll_tick) begin
                m_scroll++;
                if (m_scroll == 72) m_state = 3;
            end
        end else if (m_state == 2 && !pause) begin
            m_state = 1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        col_req = 1'b1; rd_req = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        tests_run++;
        if ({col_gnt, rd_gnt, col_valid, rd_valid, col_state, rd_state, map_index_x,
             map_index_y, scroll_pos, run_state, level_done} !== '0)
            begin tests_failed++; $display("FAIL reset_outputs: gnt=%b%b run_state=%0d scroll=%0d expected all 0",
                col_gnt, rd_gnt, run_state, scroll_pos); end
        col_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scroll();
        start = 1'b1; next_clk(); start = 1'b0;
        tests_run++;
        if (run_state !== 2'd1 || scroll_pos !== 7'd0)
            begin tests_failed++; $display("FAIL start_run: run_state=%0d scroll=%0d expected 1/0", run_state, scroll_pos); end
        for (int i = 1; i <= 75; i++) begin
            scroll_tick = 1'b1; next_clk();
            tests_run++;
            if (scroll_pos !== 7'((i > 72) ? 72 : i) || run_state !== ((i >= 72) ? 2'd3 : 2'd1) ||
                level_done !== (i >= 72))
                begin tests_failed++; $display("FAIL scroll_step%0d: scroll=%0d run_state=%0d done=%b", i,
                    scroll_pos, run_state, level_done); end
        end
        scroll_tick = 1'b0;
    endtask

    task automatic test_pause();
        start = 1'b1; next_clk(); start = 1'b0;
        tests_run++;
        if (run_state !== 2'd1 || scroll_pos !== 7'd0 || level_done !== 1'b0)
            begin tests_failed++; $display("FAIL restart_from_done: run_state=%0d scroll=%0d expected 1/0", run_state, scroll_pos); end
        for (int i = 0; i < 10; i++) begin scroll_tick = 1'b1; next_clk(); end
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_clk();
            tests_run++;
            if (run_state !== 2'd2 || scroll_pos !== 7'd10)
                begin tests_failed++; $display("FAIL pause_tick%0d: run_state=%0d scroll=%0d expected 2/10", i, run_state, scroll_pos); end
        end
        pause = 1'b0; scroll_tick = 1'b0; next_clk();
        tests_run++;
        if (run_state !== 2'd1 || scroll_pos !== 7'd10)
            begin tests_failed++; $display("FAIL unpause: run_state=%0d scroll=%0d expected 1/10", run_state, scroll_pos); end
    endtask

    task automatic test_address();
        int t_own[7]  = '{0, 0, 0, 1, 0, 1, 0};
        int t_lane[7] = '{0, 5, 2, 4, 1, 3, 3};
        int t_row[7]  = '{3, 3, 80, 14, 76, 76, 0};
        int t_tick[7] = '{0, 0, 0, 0, 1, 0, 0};
        exp_t e;
        logic [1:0] g;
        logic [2:0] st;
        int abs_r;
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({col_valid, rd_valid} !== {!e.owner, e.owner} || (e.owner ? rd_state : col_state) !== e.st)
                    begin tests_failed++; $display("FAIL addr_result%0d: valid=%b%b state=%0d/%0d expected owner=%0d state=%0d",
                        k, col_valid, rd_valid, col_state, rd_state, e.owner, e.st); end
            end else begin
                tests_run++;
                if (col_valid !== 1'b0 || rd_valid !== 1'b0)
                    begin tests_failed++; $display("FAIL addr_stray%0d: valid=%b%b expected 00", k, col_valid, rd_valid); end
            end
            if (k > 0) begin
                tests_run++;
                if (map_index_x !== 3'(m_ix) || map_index_y !== 7'(m_iy))
                    begin tests_failed++; $display("FAIL addr_index%0d: x=%0d y=%0d expected %0d/%0d", k,
                        map_index_x, map_index_y, m_ix, m_iy); end
            end
            if (k < 7) begin
                col_req = (t_own[k] == 0); rd_req = (t_own[k] == 1);
                col_lane = 3'(t_lane[k]); rd_lane = 3'(t_lane[k]);
                col_row = 7'(t_row[k]); rd_row = 7'(t_row[k]);
                scroll_tick = (t_tick[k] != 0);
            end else begin
                col_req = 1'b0; rd_req = 1'b0; scroll_tick = 1'b0;
            end
            #1;
            g = arb_exp();
            tests_run++;
            if ({rd_gnt, col_gnt} !== g)
                begin tests_failed++; $display("FAIL addr_gnt%0d: rd/col=%b%b expected %b", k, rd_gnt, col_gnt, g); end
            if (g != 2'b00) begin
                abs_r = m_scroll + t_row[k];
                if (t_lane[k] >= 5) st = 3'd1;
                else if (abs_r >= 87) st = 3'd0;
                else begin
                    st = rom_f(3'(t_lane[k]), 7'(abs_r));
                    m_ix = t_lane[k]; m_iy = abs_r;
                end
                exp_q.push_back('{cyc + 2, g[1], st});
            end
            next_clk();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int abs_r;
        bit exp_r;
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({col_valid, rd_valid} !== {!e.owner, e.owner} || (e.owner ? rd_state : col_state) !== e.st)
                    begin tests_failed++; $display("FAIL b2b_result%0d: valid=%b%b state=%0d/%0d expected owner=%0d state=%0d",
                        i, col_valid, rd_valid, col_state, rd_state, e.owner, e.st); end
            end else begin
                tests_run++;
                if (col_valid !== 1'b0 || rd_valid !== 1'b0)
                    begin tests_failed++; $display("FAIL b2b_stray%0d: valid=%b%b expected 00", i, col_valid, rd_valid); end
            end
            if (i < 12) begin
                col_req = 1'b1; rd_req = 1'b1;
                col_lane = 3'($urandom_range(0, 4)); rd_lane = 3'($urandom_range(0, 4));
                col_row = 7'($urandom_range(0, 14)); rd_row = 7'($urandom_range(0, 14));
                #1;
                exp_r = ((i % 4) == 3);
                tests_run++;
                if (col_gnt !== !exp_r || rd_gnt !== exp_r)
                    begin tests_failed++; $display("FAIL b2b_gnt%0d: col=%b rd=%b expected rd=%0d", i, col_gnt, rd_gnt, exp_r); end
                abs_r = m_scroll + int'(exp_r ? rd_row : col_row);
                exp_q.push_back('{cyc + 2, exp_r, rom_f(exp_r ? rd_lane : col_lane, 7'(abs_r))});
            end else begin
                col_req = 1'b0; rd_req = 1'b0;
            end
            next_clk();
        end
        tests_run++;
        if (exp_q.size() != 0)
            begin tests_failed++; $display("FAIL b2b_drain: %0d results outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_inflight();
        col_req = 1'b1; col_lane = 3'd1; col_row = 7'd2; #1;
        tests_run++;
        if (col_gnt !== 1'b1) begin tests_failed++; $display("FAIL inflight_col_gnt: got %b expected 1", col_gnt); end
        next_clk();
        col_req = 1'b0; rd_req = 1'b1; rd_lane = 3'd2; rd_row = 7'd3; #1;
        tests_run++;
        if (rd_gnt !== 1'b1) begin tests_failed++; $display("FAIL inflight_rd_gnt: got %b expected 1", rd_gnt); end
        next_clk();
        rd_req = 1'b0; rst_n = 1'b0; #1;
        tests_run++;
        if ({col_valid, rd_valid, col_state, rd_state, map_index_x, map_index_y,
             scroll_pos, run_state, level_done} !== '0)
            begin tests_failed++; $display("FAIL inflight_reset_outputs: valid=%b%b run_state=%0d scroll=%0d expected all 0",
                col_valid, rd_valid, run_state, scroll_pos); end
        @(negedge clk);
        rst_n = 1'b1;
        m_state = 0; m_scroll = 0; m_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            next_clk();
            tests_run++;
            if (col_valid !== 1'b0 || rd_valid !== 1'b0 || run_state !== 2'd0)
                begin tests_failed++; $display("FAIL post_reset%0d: valid=%b%b run_state=%0d expected 00/0", i,
                    col_valid, rd_valid, run_state); end
        end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_pause();
        test_address();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
